rtc_prog_editor: RTL and testbench

//  Consumes the 2-bit programming-mode code from the switch decoder (00 none, 01 date, 10 time, 11 timer).

---
 rtl/rtc_prog_pkg.sv | 56 +++++
 rtl/rtc_prog_editor_bcd_step.sv | 32 +++
 rtl/rtc_prog_editor.sv | 200 ++++++++++++++++++++
 tb/tb_rtc_prog_editor.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/rtc_prog_pkg.sv
// Shared constants for the RTC programming editor: mode codes, FSM encoding
// and per-mode BCD field limits.
package rtc_prog_pkg;

  localparam logic [1:0] MODE_NONE  = 2'b00;
  localparam logic [1:0] MODE_DATE  = 2'b01;
  localparam logic [1:0] MODE_TIME  = 2'b10;
  localparam logic [1:0] MODE_TIMER = 2'b11;

  localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
  localparam logic [1:0] ST_LOAD_ENC   = 2'd1;
  localparam logic [1:0] ST_EDIT_ENC   = 2'd2;
  localparam logic [1:0] ST_COMMIT_ENC = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = ST_IDLE_ENC,
    ST_LOAD   = ST_LOAD_ENC,
    ST_EDIT   = ST_EDIT_ENC,
    ST_COMMIT = ST_COMMIT_ENC
  } state_e;

  localparam logic [7:0] DATE_DAY_MIN   = 8'h01;
  localparam logic [7:0] DATE_DAY_MAX   = 8'h31;
  localparam logic [7:0] DATE_MONTH_MIN = 8'h01;
  localparam logic [7:0] DATE_MONTH_MAX = 8'h12;
  localparam logic [7:0] DATE_YEAR_MIN  = 8'h00;
  localparam logic [7:0] DATE_YEAR_MAX  = 8'h99;
  localparam logic [7:0] TIME_HOUR_MIN  = 8'h00;
  localparam logic [7:0] TIME_HOUR_MAX  = 8'h23;
  localparam logic [7:0] TIME_MS_MIN    = 8'h00;
  localparam logic [7:0] TIME_MS_MAX    = 8'h59;

  // Time and timer share ranges; MODE_NONE never edits, so it falls in with them.
  function automatic logic [7:0] fieldMin(input logic [1:0] mode, input logic [1:0] idx);
    if (mode == MODE_DATE) begin
      case (idx)
        2'd0:    return DATE_DAY_MIN;
        2'd1:    return DATE_MONTH_MIN;
        default: return DATE_YEAR_MIN;
      endcase
    end
    return (idx == 2'd0) ? TIME_HOUR_MIN : TIME_MS_MIN;
  endfunction

  function automatic logic [7:0] fieldMax(input logic [1:0] mode, input logic [1:0] idx);
    if (mode == MODE_DATE) begin
      case (idx)
        2'd0:    return DATE_DAY_MAX;
        2'd1:    return DATE_MONTH_MAX;
        default: return DATE_YEAR_MAX;
      endcase
    end
    return (idx == 2'd0) ? TIME_HOUR_MAX : TIME_MS_MAX;
  endfunction

endpackage

// File: rtl/rtc_prog_editor_bcd_step.sv
// Wrapping BCD increment/decrement of one field with a range/validity clamp;
// invalid inputs come out as the field minimum.
module rtc_bcd_step (
  input  logic [7:0] in_i,
  input  logic [7:0] min_i,
  input  logic [7:0] max_i,
  input  logic       up_i,
  input  logic       down_i,
  output logic [7:0] out_o
);

  logic       valid;
  logic [7:0] inc;
  logic [7:0] dec;

  // Packed BCD orders the same as binary, so plain compares do the range check.
  always_comb begin
    valid = (in_i[7:4] <= 4'd9) && (in_i[3:0] <= 4'd9) &&
            (in_i >= min_i) && (in_i <= max_i);
    inc   = (in_i[3:0] == 4'd9) ? {in_i[7:4] + 4'd1, 4'd0} : {in_i[7:4], in_i[3:0] + 4'd1};
    dec   = (in_i[3:0] == 4'd0) ? {in_i[7:4] - 4'd1, 4'd9} : {in_i[7:4], in_i[3:0] - 4'd1};
    out_o = in_i;
    if (!valid) begin
      out_o = min_i;
    end else if (up_i && !down_i) begin
      out_o = (in_i == max_i) ? min_i : inc;
    end else if (down_i && !up_i) begin
      out_o = (in_i == min_i) ? max_i : dec;
    end
  end

endmodule

// File: rtl/rtc_prog_editor.sv
// RTC programming editor: loads three BCD fields on mode entry, edits them with
// button pulses, and strobes them out on mode exit. Blinking: RTC_BLINK_EN.
module rtc_prog_editor
  import rtc_prog_pkg::*;
#(
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] programacion,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic [7:0] rd_f0,
  input  logic [7:0] rd_f1,
  input  logic [7:0] rd_f2,
  output logic       rd_req,
  output logic       editing,
  output logic [1:0] cursor,
  output logic [7:0] f0,
  output logic [7:0] f1,
  output logic [7:0] f2,
  output logic       wr_stb,
  output logic [1:0] wr_mode,
  output logic [2:0] blink_mask
);

  state_e     state_q, state_d;
  logic [1:0] mode_q, mode_d;
  logic [1:0] cursor_q, cursor_d;
  logic [7:0] f_q [3];
  logic [7:0] f_d [3];
  logic       rd_req_q, rd_req_d;
  logic       editing_q, editing_d;
  logic       wr_stb_q, wr_stb_d;
  logic [1:0] wr_mode_q, wr_mode_d;

  logic [7:0] rd_val [3];
  logic [7:0] load_val [3];
  logic [7:0] sel_field;
  logic [7:0] step_out;

  assign rd_val[0] = rd_f0;
  assign rd_val[1] = rd_f1;
  assign rd_val[2] = rd_f2;

  for (genvar i = 0; i < 3; i++) begin : g_load
    rtc_bcd_step u_clamp (
      .in_i   (rd_val[i]),
      .min_i  (fieldMin(mode_q, 2'(i))),
      .max_i  (fieldMax(mode_q, 2'(i))),
      .up_i   (1'b0),
      .down_i (1'b0),
      .out_o  (load_val[i])
    );
  end

  always_comb begin
    case (cursor_q)
      2'd1:    sel_field = f_q[1];
      2'd2:    sel_field = f_q[2];
      default: sel_field = f_q[0];
    endcase
  end

  rtc_bcd_step u_step (
    .in_i   (sel_field),
    .min_i  (fieldMin(mode_q, cursor_q)),
    .max_i  (fieldMax(mode_q, cursor_q)),
    .up_i   (btn_up),
    .down_i (btn_down),
    .out_o  (step_out)
  );

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    cursor_d  = cursor_q;
    f_d       = f_q;
    wr_stb_d  = 1'b0;
    wr_mode_d = 2'b00;
    case (state_q)
      ST_IDLE: begin
        if (programacion != MODE_NONE) begin
          mode_d  = programacion;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        f_d      = load_val;
        cursor_d = 2'd0;
        state_d  = ST_EDIT;
      end
      ST_EDIT: begin
        if (programacion != mode_q) begin
          state_d = ST_COMMIT;
        end else begin
          // Step lands on the old cursor field even if the cursor also moves.
          for (int i = 0; i < 3; i++) begin
            if (cursor_q == 2'(i)) f_d[i] = step_out;
          end
          if (btn_right && !btn_left) begin
            cursor_d = (cursor_q == 2'd2) ? 2'd0 : cursor_q + 2'd1;
          end else if (btn_left && !btn_right) begin
            cursor_d = (cursor_q == 2'd0) ? 2'd2 : cursor_q - 2'd1;
          end
        end
      end
      ST_COMMIT: begin
        wr_stb_d  = 1'b1;
        wr_mode_d = mode_q;
        if (programacion == MODE_NONE) begin
          state_d = ST_IDLE;
        end else begin
          mode_d  = programacion;
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    rd_req_d  = (state_d == ST_LOAD);
    editing_d = (state_d == ST_EDIT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_NONE;
      cursor_q  <= 2'd0;
      for (int i = 0; i < 3; i++) f_q[i] <= 8'h00;
      rd_req_q  <= 1'b0;
      editing_q <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_mode_q <= 2'b00;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      cursor_q  <= cursor_d;
      f_q       <= f_d;
      rd_req_q  <= rd_req_d;
      editing_q <= editing_d;
      wr_stb_q  <= wr_stb_d;
      wr_mode_q <= wr_mode_d;
    end
  end

  assign rd_req  = rd_req_q;
  assign editing = editing_q;
  assign cursor  = cursor_q;
  assign f0      = f_q[0];
  assign f1      = f_q[1];
  assign f2      = f_q[2];
  assign wr_stb  = wr_stb_q;
  assign wr_mode = wr_mode_q;

`ifdef RTC_BLINK_EN
  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic [2:0]    mask_q, mask_d;

  // Restarting on a cursor move shows the newly selected field steadily first.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (state_q == ST_LOAD || (state_q == ST_EDIT && cursor_d != cursor_q)) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (state_q == ST_EDIT) begin
      if (cnt_q == CW'(BLINK_DIV - 1)) begin
        cnt_d   = '0;
        phase_d = !phase_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    mask_d = (state_d == ST_EDIT) ? ~((3'b001 << cursor_d) & {3{phase_d}}) : 3'b111;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
      mask_q  <= 3'b000;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      mask_q  <= mask_d;
    end
  end

  assign blink_mask = mask_q;
`else
  // Solid display; the divider only matters when blinking is compiled in.
  assign blink_mask = {3{BLINK_DIV > 0}};
`endif

endmodule

// File: tb/tb_rtc_prog_editor.sv
// Self-checking bench for rtc_prog_editor: a table of date-edit vectors plus
// hand-written time/timer, clamp, reset and blink sequences.
module tb_rtc_prog_editor;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] programacion;
  logic       btn_up, btn_down, btn_left, btn_right;
  logic [7:0] rd_f0, rd_f1, rd_f2;
  logic       rd_req, editing, wr_stb;
  logic [1:0] cursor, wr_mode;
  logic [7:0] f0, f1, f2;
  logic [2:0] blink_mask;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [1:0] prog;
    logic       up, down, left, right;
    logic       rdReq, editing, wrStb;
    logic [1:0] wrMode, cursor;
    logic [7:0] f0, f1, f2;
  } vec_t;

  vec_t vecs [17];

  rtc_prog_editor #(.BLINK_DIV(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .programacion (programacion),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .rd_f0        (rd_f0),
    .rd_f1        (rd_f1),
    .rd_f2        (rd_f2),
    .rd_req       (rd_req),
    .editing      (editing),
    .cursor       (cursor),
    .f0           (f0),
    .f1           (f1),
    .f2           (f2),
    .wr_stb       (wr_stb),
    .wr_mode      (wr_mode),
    .blink_mask   (blink_mask)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic eRdReq, input logic eEditing,
                          input logic eWrStb, input logic [1:0] eWrMode, input logic [1:0] eCursor,
                          input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
    checkOutput({tag, ".rd_req"},  {7'd0, rd_req},  {7'd0, eRdReq});
    checkOutput({tag, ".editing"}, {7'd0, editing}, {7'd0, eEditing});
    checkOutput({tag, ".wr_stb"},  {7'd0, wr_stb},  {7'd0, eWrStb});
    checkOutput({tag, ".wr_mode"}, {6'd0, wr_mode}, {6'd0, eWrMode});
    checkOutput({tag, ".cursor"},  {6'd0, cursor},  {6'd0, eCursor});
    checkOutput({tag, ".f0"}, f0, e0);
    checkOutput({tag, ".f1"}, f1, e1);
    checkOutput({tag, ".f2"}, f2, e2);
  endtask

  // Buttons are held for exactly one rising edge, as the debouncer would.
  task automatic applyStimulus(input logic [1:0] prog, input logic u, input logic d,
                               input logic l, input logic r);
    programacion = prog;
    btn_up = u; btn_down = d; btn_left = l; btn_right = r;
    tick();
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
  endtask

  initial begin
    //          prog  u  d  l  r  rdq ed wr wm     cur    f0     f1     f2
    vecs[0]  = '{2'b01, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'd0, 8'h00, 8'h00, 8'h00};
    vecs[1]  = '{2'b01, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'd0, 8'h31, 8'h12, 8'h99};
    vecs[2]  = '{2'b01, 1, 0, 0, 0, 0, 1, 0, 2'b00, 2'd0, 8'h01, 8'h12, 8'h99};
    vecs[3]  = '{2'b01, 0, 1, 0, 0, 0, 1, 0, 2'b00, 2'd0, 8'h31, 8'h12, 8'h99};
    vecs[4]  = '{2'b01, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'd1, 8'h31, 8'h12, 8'h99};
    vecs[5]  = '{2'b01, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'd2, 8'h31, 8'h12, 8'h99};
    vecs[6]  = '{2'b01, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'd0, 8'h31, 8'h12, 8'h99};
    vecs[7]  = '{2'b01, 0, 0, 1, 0, 0, 1, 0, 2'b00, 2'd2, 8'h31, 8'h12, 8'h99};
    vecs[8]  = '{2'b01, 1, 0, 0, 0, 0, 1, 0, 2'b00, 2'd2, 8'h31, 8'h12, 8'h00};
    vecs[9]  = '{2'b01, 0, 1, 0, 0, 0, 1, 0, 2'b00, 2'd2, 8'h31, 8'h12, 8'h99};
    vecs[10] = '{2'b01, 1, 1, 0, 0, 0, 1, 0, 2'b00, 2'd2, 8'h31, 8'h12, 8'h99};
    vecs[11] = '{2'b01, 0, 0, 1, 1, 0, 1, 0, 2'b00, 2'd2, 8'h31, 8'h12, 8'h99};
    vecs[12] = '{2'b01, 1, 0, 1, 0, 0, 1, 0, 2'b00, 2'd1, 8'h31, 8'h12, 8'h00};
    vecs[13] = '{2'b01, 0, 1, 0, 0, 0, 1, 0, 2'b00, 2'd1, 8'h31, 8'h11, 8'h00};
    vecs[14] = '{2'b00, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'd1, 8'h31, 8'h11, 8'h00};
    vecs[15] = '{2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b01, 2'd1, 8'h31, 8'h11, 8'h00};
    vecs[16] = '{2'b00, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'd1, 8'h31, 8'h11, 8'h00};

    reset = 1'b1;
    programacion = 2'b00;
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    rd_f0 = 8'h31; rd_f1 = 8'h12; rd_f2 = 8'h99;
    tick();
    tick();
    checkAll("reset", 0, 0, 0, 2'b00, 2'd0, 8'h00, 8'h00, 8'h00);
    reset = 1'b0;

    // Date entry, edits, wraps, simultaneous buttons, exit to idle.
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].prog, vecs[i].up, vecs[i].down, vecs[i].left, vecs[i].right);
      checkAll($sformatf("vec%0d", i), vecs[i].rdReq, vecs[i].editing, vecs[i].wrStb,
               vecs[i].wrMode, vecs[i].cursor, vecs[i].f0, vecs[i].f1, vecs[i].f2);
    end

    // Time mode: 59 up wraps to 00, hour 00 down wraps to 23, 7A loads as 00.
    rd_f0 = 8'h00; rd_f1 = 8'h59; rd_f2 = 8'h7A;
    applyStimulus(2'b10, 0, 0, 0, 0);
    checkAll("time.load", 1, 0, 0, 2'b00, 2'd1, 8'h31, 8'h11, 8'h00);
    applyStimulus(2'b10, 0, 0, 0, 0);
    checkAll("time.edit", 0, 1, 0, 2'b00, 2'd0, 8'h00, 8'h59, 8'h00);
    applyStimulus(2'b10, 0, 0, 0, 1);
    applyStimulus(2'b10, 1, 0, 0, 0);
    checkAll("time.minup", 0, 1, 0, 2'b00, 2'd1, 8'h00, 8'h00, 8'h00);
    applyStimulus(2'b10, 0, 0, 1, 0);
    applyStimulus(2'b10, 0, 1, 0, 0);
    checkAll("time.hourdn", 0, 1, 0, 2'b00, 2'd0, 8'h23, 8'h00, 8'h00);

    // Direct mode switches commit the old mode and reload the new one.
    rd_f0 = 8'h12; rd_f1 = 8'h34; rd_f2 = 8'h56;
    applyStimulus(2'b11, 0, 0, 0, 0);
    checkAll("sw11.commit", 0, 0, 0, 2'b00, 2'd0, 8'h23, 8'h00, 8'h00);
    applyStimulus(2'b11, 0, 0, 0, 0);
    checkAll("sw11.strobe", 1, 0, 1, 2'b10, 2'd0, 8'h23, 8'h00, 8'h00);
    applyStimulus(2'b11, 0, 0, 0, 0);
    checkAll("sw11.edit", 0, 1, 0, 2'b00, 2'd0, 8'h12, 8'h34, 8'h56);
    applyStimulus(2'b10, 0, 0, 0, 0);
    applyStimulus(2'b10, 0, 0, 0, 0);
    checkAll("sw10.strobe", 1, 0, 1, 2'b11, 2'd0, 8'h12, 8'h34, 8'h56);
    applyStimulus(2'b10, 0, 0, 0, 0);
    checkAll("sw10.edit", 0, 1, 0, 2'b00, 2'd0, 8'h12, 8'h34, 8'h56);
    applyStimulus(2'b00, 0, 0, 0, 0);
    checkAll("exit.commit", 0, 0, 0, 2'b00, 2'd0, 8'h12, 8'h34, 8'h56);
    applyStimulus(2'b00, 0, 0, 0, 0);
    checkAll("exit.strobe", 0, 0, 1, 2'b10, 2'd0, 8'h12, 8'h34, 8'h56);
    applyStimulus(2'b00, 0, 0, 0, 0);
    checkAll("exit.idle", 0, 0, 0, 2'b00, 2'd0, 8'h12, 8'h34, 8'h56);

    // Out-of-range date loads clamp to minimums; day 01 down wraps to 31.
    rd_f0 = 8'h32; rd_f1 = 8'h00; rd_f2 = 8'h5F;
    applyStimulus(2'b01, 0, 0, 0, 0);
    applyStimulus(2'b01, 0, 0, 0, 0);
    checkAll("clamp.edit", 0, 1, 0, 2'b00, 2'd0, 8'h01, 8'h01, 8'h00);
    applyStimulus(2'b01, 0, 1, 0, 0);
    checkAll("clamp.daydn", 0, 1, 0, 2'b00, 2'd0, 8'h31, 8'h01, 8'h00);

    applyStimulus(2'b01, 0, 0, 0, 1);
`ifdef RTC_BLINK_EN
    for (int i = 0; i < 8; i++) begin
      if (i > 0) applyStimulus(2'b01, 0, 0, 0, 0);
      checkOutput($sformatf("blink%0d", i), {5'd0, blink_mask}, (i < 4) ? 8'h07 : 8'h05);
    end
`else
    checkOutput("blink.solid", {5'd0, blink_mask}, 8'h07);
`endif

    // Reset mid-edit discards everything and must not produce a strobe.
    programacion = 2'b00;
    reset = 1'b1;
    tick();
    checkAll("rstedit", 0, 0, 0, 2'b00, 2'd0, 8'h00, 8'h00, 8'h00);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'b00, 0, 0, 0, 0);
      checkAll($sformatf("postrst%0d", i), 0, 0, 0, 2'b00, 2'd0, 8'h00, 8'h00, 8'h00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
